// File: rtl/qbus_master.sv
// QBUS-style single-master bus cycle sequencer: host request/response in, SYNC/DIN/DOUT cycles out.
// Defining QBM_TIMEOUT_EN adds an RPLY wait limit of TIMEOUT cycles over DATA and RELEASE.
module qbus_master #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  input  logic        req_we,
  input  logic        req_byte,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        SYNC,
  output logic        DIN,
  output logic        DOUT,
  output logic        WTBT,
  output logic [15:0] addr_o,
  output logic [15:0] data_o,
  input  logic [15:0] data_i,
  input  logic        RPLY
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ADDR    = 2'd1;
  localparam logic [1:0] DATA    = 2'd2;
  localparam logic [1:0] RELEASE = 2'd3;

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("qbus_master: TIMEOUT must be in 1..255");
  end

  logic [1:0]  state;
  logic        lat_we;
  logic        lat_byte;
  logic [15:0] lat_addr;
  logic [15:0] lat_wdata;
  logic        handshake;
  logic        misaligned;
  logic        tmo_hit;
  logic [15:0] rd_capture;

  assign req_ready  = (state == IDLE);
  assign handshake  = req_valid & req_ready;
  assign misaligned = ~req_byte & req_addr[0];

  assign SYNC   = (state != IDLE);
  assign DIN    = (state == DATA) & ~lat_we;
  assign DOUT   = (state == DATA) & lat_we;
  assign WTBT   = lat_byte;
  assign addr_o = lat_addr;
  assign data_o = lat_wdata;

  // Byte reads return the addressed lane right-justified.
  always_comb begin
    rd_capture = data_i;
    if (lat_byte) begin
      rd_capture = lat_addr[0] ? {8'h00, data_i[15:8]} : {8'h00, data_i[7:0]};
    end
  end

`ifdef QBM_TIMEOUT_EN
  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);
  logic [7:0] tmo_cnt;

  assign tmo_hit = ((state == DATA) || (state == RELEASE)) && (tmo_cnt + 8'd1 == TimeoutCnt);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt <= 8'd0;
    end else if (state == ADDR) begin
      tmo_cnt <= 8'd0;
    end else if ((state == DATA) || (state == RELEASE)) begin
      tmo_cnt <= tmo_cnt + 8'd1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      lat_we    <= 1'b0;
      lat_byte  <= 1'b0;
      lat_addr  <= 16'h0000;
      lat_wdata <= 16'h0000;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 16'h0000;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      if (tmo_hit) begin
        state     <= IDLE;
        rsp_valid <= 1'b1;
        rsp_err   <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (handshake) begin
              lat_we    <= req_we;
              lat_byte  <= req_byte;
              lat_addr  <= req_addr;
              // Odd byte writes drive the high lane; replicate so either lane is correct.
              lat_wdata <= (req_byte & req_addr[0]) ? {req_wdata[7:0], req_wdata[7:0]}
                                                    : req_wdata;
              if (misaligned) begin
                rsp_valid <= 1'b1;
                rsp_err   <= 1'b1;
              end else begin
                state <= ADDR;
              end
            end
          end
          ADDR: state <= DATA;
          DATA: begin
            if (RPLY) begin
              state <= RELEASE;
              if (!lat_we) rsp_rdata <= rd_capture;
            end
          end
          RELEASE: begin
            if (!RPLY) begin
              state     <= IDLE;
              rsp_valid <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/qbus_master.md
QBUS_MASTER -- requirements
Module: qbus_master

Interface
REQ-001 Parameter TIMEOUT, default 64, is the RPLY wait limit in clk cycles (legal 1..255).
REQ-002 clk  in  1  single clock; all state changes on the rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 req_valid  in  1  host transfer request.
REQ-005 req_ready  out  1  block can accept a request.
REQ-006 req_addr  in  16  byte address.
REQ-007 req_wdata  in  16  write data.
REQ-008 req_we  in  1  1 = write, 0 = read.
REQ-009 req_byte  in  1  1 = byte transfer.
REQ-010 rsp_valid  out  1  one-cycle completion pulse.
REQ-011 rsp_rdata  out  16  read result.
REQ-012 rsp_err  out  1  error flag, qualified by rsp_valid.
REQ-013 SYNC  out  1  bus cycle active.
REQ-014 DIN  out  1  read strobe.
REQ-015 DOUT  out  1  write strobe.
REQ-016 WTBT  out  1  byte transfer.
REQ-017 addr_o  out  16  bus address.
REQ-018 data_o  out  16  bus write data.
REQ-019 data_i  in  16  bus read data.
REQ-020 RPLY  in  1  responder reply.

Function
REQ-021 States SHALL be IDLE, ADDR, DATA, RELEASE.
- req_ready = 1 only in IDLE.
- A handshake is req_valid & req_ready.
REQ-022 On handshake, the block SHALL latch addr, wdata, we and byte, then:
- go to ADDR next cycle;
- exception: word request with req_addr[0]=1 stays in IDLE, asserts no bus strobe, and pulses rsp_valid=1, rsp_err=1 next cycle.
REQ-023 ADDR, exactly one cycle:
- SYNC=1, DIN=DOUT=0;
- addr_o = latched addr, WTBT = latched byte.
REQ-024 DATA:
- SYNC=1; DIN = ~we, DOUT = we;
- data_o = {wdata[7:0],wdata[7:0]} for byte write to odd address, else wdata;
- stay until RPLY sampled 1.
REQ-025 Read capture on the RPLY=1 edge in DATA:
- word: rsp_rdata = data_i;
- byte, even address: {8'h00,data_i[7:0]};
- byte, odd address: {8'h00,data_i[15:8]}.
REQ-026 RELEASE:
- DIN=DOUT=0, SYNC=1;
- stay until RPLY sampled 0, then go to IDLE with SYNC=0.
REQ-027 rsp_valid SHALL pulse for exactly the first IDLE cycle after RELEASE (rsp_err=0).
- A new handshake in that same cycle SHALL be accepted.
REQ-028 Minimum latency, handshake at edge T with RPLY responding immediately:
- ADDR at T+1, DATA at T+2, RELEASE at T+3, rsp_valid at T+4.
REQ-029 RPLY SHALL be ignored in IDLE and ADDR.
- RPLY already 1 on entry to DATA completes DATA after one cycle.
REQ-030 addr_o, data_o and WTBT SHALL hold stable from ADDR through RELEASE.
REQ-031 rsp_rdata SHALL hold until the next read completes.
- Writes and errors leave rsp_rdata unchanged.

Reset
REQ-032 While reset_n=0, asynchronously:
- state=IDLE;
- SYNC=DIN=DOUT=WTBT=0;
- rsp_valid=rsp_err=0;
- addr_o=data_o=rsp_rdata=0;
- timeout counter=0.
REQ-033 Reset asserted mid-transfer SHALL abort it with no rsp_valid.
- req_ready=1 in the first cycle after reset_n rises.

Configuration
REQ-034 With QBM_TIMEOUT_EN defined, an 8-bit counter SHALL clear on entry to DATA and count cycles in DATA and RELEASE.
- On reaching TIMEOUT, the block goes to IDLE and drops SYNC/DIN/DOUT that cycle.
- rsp_valid=1, rsp_err=1 next cycle; rsp_rdata is not updated.
REQ-035 Without QBM_TIMEOUT_EN, no counter SHALL exist; DATA and RELEASE wait indefinitely.

Verification
REQ-036 Word read addr 16'o1000, responder RPLY after 3 cycles with data_i=16'h1234 -> DIN high 3 cycles, rsp_rdata=16'h1234, rsp_err=0, one rsp_valid pulse.
REQ-037 Byte write addr 16'o1001, wdata=16'h00A5 -> WTBT=1, DOUT=1, data_o=16'hA5A5 during DATA; rsp_valid with rsp_err=0.
REQ-038 Byte read addr 16'o1001, data_i=16'hBEEF -> rsp_rdata=16'h00BE; same access at addr 16'o1000 -> 16'h00EF.
REQ-039 Word read addr 16'o1001 -> no SYNC, rsp_valid=1, rsp_err=1 one cycle after the handshake.
REQ-040 QBM_TIMEOUT_EN defined, TIMEOUT=8, RPLY held 0 -> strobes drop after 8 DATA cycles, rsp_err=1; undefined -> SYNC/DIN held for 1000 cycles.
REQ-041 reset_n pulsed low during DATA -> all outputs 0 immediately, no rsp_valid, next request completes normally.
